// File: rtl/bundle_sequencer_if.sv
// Fetch-port, issue-port and FU-feedback signals shared by the bundle sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the mmu/FU side.
interface bundle_sequencer_if #(
  parameter int NFU    = 8,
  parameter int SLOT_W = 32,
  parameter int PC_W   = 64
);
  localparam int BW = NFU * SLOT_W;

  logic                 fetch_req;
  logic [PC_W-1:0]      fetch_addr;
  logic                 fetch_ack;
  logic [BW-1:0]        fetch_data;
  logic                 fetch_fault;
  logic                 bundle_valid;
  logic [BW-1:0]        bundle;
  logic [PC_W-1:0]      bundle_pc;
  logic [NFU-1:0]       fu_busy;
  logic [NFU-1:0]       pc_write;
  logic [NFU*PC_W-1:0]  pc_new;
  logic                 halted;

  modport master (
    output fetch_req, fetch_addr, bundle_valid, bundle, bundle_pc, halted,
    input  fetch_ack, fetch_data, fetch_fault, fu_busy, pc_write, pc_new
  );

  modport slave (
    input  fetch_req, fetch_addr, bundle_valid, bundle, bundle_pc, halted,
    output fetch_ack, fetch_data, fetch_fault, fu_busy, pc_write, pc_new
  );
endinterface

// File: rtl/bundle_sequencer.sv
// VLIW fetch/issue sequencer: prefetches bundles into a DEPTH-entry queue over a req/ack port
// and issues them one at a time, handling FU redirects (lowest FU wins) and fetch faults.
module bundle_sequencer #(
  parameter int              NFU      = 8,
  parameter int              SLOT_W   = 32,
  parameter int              PC_W     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  bundle_sequencer_if.master bus
);
  localparam int              BW      = NFU * SLOT_W;
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(BW / 8);

  typedef enum logic {ST_READY, ST_EXEC} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_first_exec, w_first_nxt;

  logic [BW-1:0]    r_q_data [DEPTH];
  logic [PC_W-1:0]  r_q_pc   [DEPTH];
  logic [DEPTH-1:0] r_q_fault;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             r_fetch_req, r_discard, r_fault_seen, r_halted;
  logic [PC_W-1:0]  r_fetch_addr;
  logic             r_bundle_valid;
  logic [BW-1:0]    r_bundle;
  logic [PC_W-1:0]  r_bundle_pc;

  logic             w_ack, w_push, w_pop, w_complete, w_redirect, w_halt_now, w_raise;
  logic [CNT_W-1:0] w_inflight;
  logic [PC_W-1:0]  w_target;

  // An ack only counts against a live request; stray or discarded acks are ignored.
  assign w_ack      = bus.fetch_ack && r_fetch_req;
  assign w_redirect = w_complete && (bus.pc_write != '0);
  assign w_push     = w_ack && !w_redirect;
  assign w_inflight = r_count + CNT_W'(r_fetch_req || r_discard);
  assign w_raise    = !r_fetch_req && !r_discard && !r_fault_seen && !r_halted &&
                      !w_redirect && (w_inflight < CNT_W'(DEPTH));

  // Scan from the top down so the lowest requesting FU is the last writer and wins.
  always_comb begin
    w_target = '0;
    for (int i = NFU - 1; i >= 0; i--) begin
      if (bus.pc_write[i]) w_target = bus.pc_new[PC_W*i +: PC_W];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_first_nxt = 1'b0;
    w_pop       = 1'b0;
    w_complete  = 1'b0;
    w_halt_now  = 1'b0;
    case (r_state)
      ST_READY: begin
        if (r_count != '0 && !r_halted) begin
          if (r_q_fault[r_rd_ptr]) begin
            w_halt_now = 1'b1;
          end else begin
            w_pop       = 1'b1;
            w_first_nxt = 1'b1;
            w_state_nxt = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // The issue cycle itself ignores fu_busy so the FUs have time to raise it.
        if (!r_first_exec && bus.fu_busy == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_READY;
        end
      end
      default: w_state_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      r_state        <= ST_READY;
      r_first_exec   <= 1'b0;
      r_fetch_req    <= 1'b0;
      r_discard      <= 1'b0;
      r_fault_seen   <= 1'b0;
      r_halted       <= 1'b0;
      r_fetch_addr   <= RESET_PC;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_bundle_valid <= 1'b0;
      r_bundle       <= '0;
      r_bundle_pc    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_first_exec   <= w_first_nxt;
      r_bundle_valid <= w_pop;
      if (w_pop) begin
        r_bundle    <= r_q_data[r_rd_ptr];
        r_bundle_pc <= r_q_pc[r_rd_ptr];
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
      end
      if (w_halt_now) r_halted <= 1'b1;

      if (w_redirect) begin
        // Flush; an in-flight request is abandoned and its eventual ack swallowed.
        r_fetch_req  <= 1'b0;
        r_discard    <= (r_fetch_req || r_discard) && !bus.fetch_ack;
        r_fetch_addr <= w_target;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
      end else begin
        if (w_ack) begin
          r_fetch_req  <= 1'b0;
          r_fetch_addr <= r_fetch_addr + PC_STEP;
          r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
          if (bus.fetch_fault) r_fault_seen <= 1'b1;
        end else if (w_raise) begin
          r_fetch_req <= 1'b1;
        end
        if (r_discard && bus.fetch_ack) r_discard <= 1'b0;
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // NOTE: queue storage is not reset; count and pointers gate every read, so contents never leak.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr]  <= bus.fetch_data;
      r_q_pc[r_wr_ptr]    <= r_fetch_addr;
      r_q_fault[r_wr_ptr] <= bus.fetch_fault;
    end
  end

  assign bus.fetch_req    = r_fetch_req;
  assign bus.fetch_addr   = r_fetch_addr;
  assign bus.bundle_valid = r_bundle_valid;
  assign bus.bundle       = r_bundle;
  assign bus.bundle_pc    = r_bundle_pc;
  assign bus.halted       = r_halted;
endmodule

// File: tb/tb_bundle_sequencer.sv
// Directed bench for bundle_sequencer: an mmu responder feeds address-derived bundles, a monitor
// logs every issue, and one task per scenario compares against hand-computed values.
module tb_bundle_sequencer;
  localparam int NFU = 8, SLOT_W = 32, PC_W = 64, DEPTH = 4;
  localparam int BW = NFU * SLOT_W;
  localparam logic [PC_W-1:0] NONE = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bundle_sequencer_if #(.NFU(NFU), .SLOT_W(SLOT_W), .PC_W(PC_W)) bus ();

  bundle_sequencer #(.NFU(NFU), .SLOT_W(SLOT_W), .PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit            mmu_en = 1'b0;
  int            mmu_fault_at = 0;
  bit            man_ack = 1'b0;
  bit            man_fault = 1'b0;
  logic [BW-1:0] man_data = '0;

  logic [PC_W-1:0] fetch_log[$];
  int              ack_cyc[$];
  logic [PC_W-1:0] issue_log[$];
  int              issue_cyc[$];

  // Bundle content is derived from its address so every issued bundle can be checked.
  function automatic logic [BW-1:0] pat(input logic [PC_W-1:0] a);
    logic [BW-1:0] r;
    for (int i = 0; i < NFU; i++) r[SLOT_W*i +: SLOT_W] = a[31:0] ^ (32'h5A00_0000 + 32'(i));
    return r;
  endfunction

  function automatic logic [PC_W-1:0] get_issue(input int i);
    return (i < issue_log.size()) ? issue_log[i] : NONE;
  endfunction

  function automatic logic [PC_W-1:0] get_fetch(input int i);
    return (i < fetch_log.size()) ? fetch_log[i] : NONE;
  endfunction

  // mmu: acks any request immediately (auto mode) or replays man_ack (manual mode); drives #1 after negedge.
  initial begin : mmu
    bus.fetch_ack   = 1'b0;
    bus.fetch_fault = 1'b0;
    bus.fetch_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.fetch_ack   = 1'b0;
      bus.fetch_fault = 1'b0;
      if (mmu_en) begin
        if (!rst && bus.fetch_req) begin
          bus.fetch_ack   = 1'b1;
          bus.fetch_data  = pat(bus.fetch_addr);
          bus.fetch_fault = (fetch_log.size() + 1 == mmu_fault_at);
          fetch_log.push_back(bus.fetch_addr);
          ack_cyc.push_back(cyc);
        end
      end else if (man_ack) begin
        bus.fetch_ack   = 1'b1;
        bus.fetch_data  = man_data;
        bus.fetch_fault = man_fault;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && bus.bundle_valid === 1'b1) begin
        issue_log.push_back(bus.bundle_pc);
        issue_cyc.push_back(cyc);
        n_checks++;
        if (bus.bundle !== pat(bus.bundle_pc)) begin
          n_fail++;
          $display("FAIL bundle_data pc=%h: got %h expected %h", bus.bundle_pc, bus.bundle, pat(bus.bundle_pc));
        end
      end
    end
  end

  task automatic do_reset(input bit auto_mmu, input int fault_at);
    @(negedge clk);
    rst = 1'b1;
    mmu_en = 1'b0;
    man_ack = 1'b0;
    bus.pc_write = '0;
    repeat (2) @(negedge clk);
    fetch_log.delete();
    ack_cyc.delete();
    issue_log.delete();
    issue_cyc.delete();
    mmu_fault_at = fault_at;
    mmu_en = auto_mmu;
    rst = 1'b0;
  endtask

  task automatic manual_ack(input logic [PC_W-1:0] a, input bit flt);
    man_data  = pat(a);
    man_fault = flt;
    man_ack   = 1'b1;
    @(negedge clk);
    man_ack   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_req: got %b expected 0", bus.fetch_req); end
    n_checks++; if (bus.fetch_addr !== 64'h0) begin n_fail++; $display("FAIL reset_fetch_addr: got %h expected 0", bus.fetch_addr); end
    n_checks++; if (bus.bundle_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bundle_valid: got %b expected 0", bus.bundle_valid); end
    n_checks++; if (bus.bundle !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h expected 0", bus.bundle); end
    n_checks++; if (bus.bundle_pc !== 64'h0) begin n_fail++; $display("FAIL reset_bundle_pc: got %h expected 0", bus.bundle_pc); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL first_req_after_reset: got %b expected 1", bus.fetch_req); end
  endtask

  task automatic test_stream();
    bit ok;
    bus.fu_busy = '0;
    do_reset(1'b1, 0);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (get_fetch(i) !== 64'(i * 32'h20)) begin n_fail++; $display("FAIL stream_fetch_addr[%0d]: got %h expected %h", i, get_fetch(i), 64'(i * 32'h20)); end
      n_checks++;
      if (get_issue(i) !== 64'(i * 32'h20)) begin n_fail++; $display("FAIL stream_bundle_pc[%0d]: got %h expected %h", i, get_issue(i), 64'(i * 32'h20)); end
    end
    // Ack captured at the edge that makes cyc = ack_cyc+1; bundle_valid is registered at the next edge.
    n_checks++;
    if (issue_cyc.size() == 0 || ack_cyc.size() == 0 || issue_cyc[0] != ack_cyc[0] + 2) begin
      n_fail++; $display("FAIL stream_first_latency: issue_cyc=%0d ack_cyc=%0d expected difference 2",
                         (issue_cyc.size() > 0) ? issue_cyc[0] : -1, (ack_cyc.size() > 0) ? ack_cyc[0] : -1);
    end
    ok = (issue_cyc.size() >= 4);
    for (int i = 1; i < issue_cyc.size(); i++) if (issue_cyc[i] - issue_cyc[i-1] < 2) ok = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_issue_spacing: got %0d issues, expected >=4 spaced >=2 cycles", issue_cyc.size()); end
  endtask

  task automatic test_backpressure();
    bus.fu_busy = '1;
    do_reset(1'b1, 0);
    repeat (20) @(negedge clk);
    n_checks++; if (fetch_log.size() != 5) begin n_fail++; $display("FAIL bp_fetch_count: got %0d expected 5", fetch_log.size()); end
    n_checks++; if (issue_log.size() != 1) begin n_fail++; $display("FAIL bp_issue_count: got %0d expected 1", issue_log.size()); end
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL bp_fetch_req_full: got %b expected 0", bus.fetch_req); end
    bus.fu_busy = '0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (get_issue(i) !== 64'(i * 32'h20)) begin n_fail++; $display("FAIL bp_release[%0d]: got %h expected %h", i, get_issue(i), 64'(i * 32'h20)); end
    end
  endtask

  task automatic test_redirect();
    bit stale;
    bus.fu_busy = '1;
    do_reset(1'b1, 0);
    repeat (20) @(negedge clk);
    bus.pc_new = '0;
    bus.pc_new[PC_W*0 +: PC_W] = 64'hDEAD_0000;
    bus.pc_new[PC_W*2 +: PC_W] = 64'h1000;
    bus.pc_new[PC_W*5 +: PC_W] = 64'h2000;
    bus.pc_write = 8'b0010_0100;
    bus.fu_busy = '0;
    @(negedge clk);
    bus.pc_write = '0;
    n_checks++; if (bus.fetch_addr !== 64'h1000) begin n_fail++; $display("FAIL redir_fetch_addr: got %h expected 1000", bus.fetch_addr); end
    repeat (30) @(negedge clk);
    n_checks++; if (get_issue(1) !== 64'h1000) begin n_fail++; $display("FAIL redir_next_pc: got %h expected 1000", get_issue(1)); end
    n_checks++; if (get_issue(2) !== 64'h1020) begin n_fail++; $display("FAIL redir_next_pc2: got %h expected 1020", get_issue(2)); end
    n_checks++; if (get_fetch(5) !== 64'h1000) begin n_fail++; $display("FAIL redir_refetch: got %h expected 1000", get_fetch(5)); end
    stale = 1'b0;
    for (int i = 1; i < issue_log.size(); i++) if (issue_log[i] < 64'h1000) stale = 1'b1;
    n_checks++; if (stale) begin n_fail++; $display("FAIL redir_stale_issue: got a pre-redirect bundle_pc, expected none"); end
  endtask

  task automatic test_redirect_outstanding();
    bit seen;
    bus.fu_busy = '1;
    do_reset(1'b0, 0);
    @(negedge clk);
    manual_ack(64'h0, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 64'h20) begin
      n_fail++; $display("FAIL ro_outstanding: got req=%b addr=%h expected req=1 addr=20", bus.fetch_req, bus.fetch_addr); end
    bus.pc_new = '0;
    bus.pc_new[PC_W*0 +: PC_W] = 64'h3000;
    bus.pc_write = 8'b0000_0001;
    bus.fu_busy = '0;
    @(negedge clk);
    bus.pc_write = '0;
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL ro_req_drop: got %b expected 0", bus.fetch_req); end
    n_checks++; if (bus.fetch_addr !== 64'h3000) begin n_fail++; $display("FAIL ro_target: got %h expected 3000", bus.fetch_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL ro_req_wait: got %b expected 0", bus.fetch_req); end
    manual_ack(64'h20, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.fetch_req === 1'b1);
    end
    n_checks++; if (!seen || bus.fetch_addr !== 64'h3000) begin
      n_fail++; $display("FAIL ro_refetch: got req=%b addr=%h expected req=1 addr=3000", bus.fetch_req, bus.fetch_addr); end
    manual_ack(64'h3000, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++; if (issue_log.size() != 2) begin n_fail++; $display("FAIL ro_issue_count: got %0d expected 2", issue_log.size()); end
    n_checks++; if (get_issue(1) !== 64'h3000) begin n_fail++; $display("FAIL ro_issue_pc: got %h expected 3000", get_issue(1)); end
  endtask

  task automatic test_fault();
    bus.fu_busy = '0;
    do_reset(1'b1, 3);
    repeat (60) @(negedge clk);
    n_checks++; if (issue_log.size() != 2) begin n_fail++; $display("FAIL fault_issue_count: got %0d expected 2", issue_log.size()); end
    n_checks++; if (get_issue(0) !== 64'h0 || get_issue(1) !== 64'h20) begin
      n_fail++; $display("FAIL fault_issue_pcs: got %h,%h expected 0,20", get_issue(0), get_issue(1)); end
    n_checks++; if (fetch_log.size() != 3) begin n_fail++; $display("FAIL fault_fetch_count: got %0d expected 3", fetch_log.size()); end
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL fault_halted: got %b expected 1", bus.halted); end
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL fault_req_low: got %b expected 0", bus.fetch_req); end
    n_checks++; if (bus.bundle_pc !== 64'h20) begin n_fail++; $display("FAIL fault_bundle_pc_held: got %h expected 20", bus.bundle_pc); end
  endtask

  task automatic test_reset_mid_fetch();
    bus.fu_busy = '0;
    do_reset(1'b0, 0);
    @(negedge clk);
    n_checks++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL rmf_req_before: got %b expected 1", bus.fetch_req); end
    rst = 1'b1;
    man_data = pat(64'hBAD0);
    man_fault = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL rmf_req_in_reset: got %b expected 0", bus.fetch_req); end
    rst = 1'b0;
    @(negedge clk);
    man_ack = 1'b0;
    n_checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 64'h0) begin
      n_fail++; $display("FAIL rmf_restart: got req=%b addr=%h expected req=1 addr=0", bus.fetch_req, bus.fetch_addr); end
    repeat (5) @(negedge clk);
    n_checks++; if (issue_log.size() != 0) begin n_fail++; $display("FAIL rmf_queue_empty: got %0d issues expected 0", issue_log.size()); end
    n_checks++; if (bus.halted !== 1'b0 || bus.fetch_addr !== 64'h0) begin
      n_fail++; $display("FAIL rmf_state: got halted=%b addr=%h expected halted=0 addr=0", bus.halted, bus.fetch_addr); end
  endtask

  initial begin
    bus.fu_busy  = '0;
    bus.pc_write = '0;
    bus.pc_new   = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_outstanding();
    test_fault();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
